// File: rtl/uart_pkg.sv
// Shared UART definitions.
//   rx_state_t        receiver FSM states
//   UART_CLK_PER_BIT  default bit period in clk cycles (115200 baud at 100 MHz)
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_t;

    localparam int UART_CLK_PER_BIT = 868;

endpackage

// File: rtl/uart_rx_if.sv
// Word handshake between the UART receiver and the decode stage.
//   rdata  assembled 32-bit word (first byte in [7:0])
//   valid  rdata holds an untaken word
//   ready  consumer accepts; transfer on valid && ready at a clk edge
//   ferr   one-cycle pulse: stop bit sampled low
//   ovr    one-cycle pulse: completed word dropped, buffer full
interface uart_rx_if;
    logic [31:0] rdata;
    logic        valid;
    logic        ready;
    logic        ferr;
    logic        ovr;

    modport master (output rdata, output valid, output ferr, output ovr, input ready);
    modport slave  (input rdata, input valid, input ferr, input ovr, output ready);
endinterface

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: rxd synchroniser, start/data/stop FSM and bit timing.
//   clk, rstn   clock, async active-low reset
//   rxd         raw serial input, idle high
//   rx_byte     last received byte, valid while byte_valid is high
//   byte_valid  one-cycle pulse after a good stop bit
//   ferr        one-cycle pulse after a low stop bit (byte discarded)
module uart_rx_byte
    import uart_pkg::*;
#(
    parameter int CLK_PER_BIT = UART_CLK_PER_BIT,
    parameter int CNT_W       = 16
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       rxd,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       ferr
);

    localparam logic [CNT_W-1:0] HALF_TC = CNT_W'(CLK_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_TC  = CNT_W'(CLK_PER_BIT - 1);

    logic [1:0]       sync;
    logic             rxd_s;
    logic [1:0]       flush;
    logic             armed;
    rx_state_t        state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [2:0]       bit_idx, bit_idx_nxt;
    logic [7:0]       shift, shift_nxt;
    logic             bv_nxt, ferr_nxt;

    assign rxd_s   = sync[1];
    assign rx_byte = shift;

    // The synchroniser resets to 1, so its first two outputs say nothing
    // about the line; only arm once a real high has come through.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync  <= 2'b11;
            flush <= 2'b00;
            armed <= 1'b0;
        end else begin
            sync  <= {sync[0], rxd};
            flush <= {flush[0], 1'b1};
            armed <= armed | (flush[1] & rxd_s);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shift      <= '0;
            byte_valid <= 1'b0;
            ferr       <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            bit_idx    <= bit_idx_nxt;
            shift      <= shift_nxt;
            byte_valid <= bv_nxt;
            ferr       <= ferr_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        bit_idx_nxt = bit_idx;
        shift_nxt   = shift;
        bv_nxt      = 1'b0;
        ferr_nxt    = 1'b0;
        case (state)
            IDLE: begin
                if (armed && !rxd_s) begin
                    state_nxt = START;
                    cnt_nxt   = '0;
                end
            end
            START: begin
                if (cnt == HALF_TC) begin
                    cnt_nxt = '0;
                    if (rxd_s) begin
                        state_nxt = IDLE;       // glitch, not a start bit
                    end else begin
                        state_nxt   = DATA;
                        bit_idx_nxt = '0;
                    end
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            DATA: begin
                if (cnt == BIT_TC) begin
                    cnt_nxt            = '0;
                    shift_nxt[bit_idx] = rxd_s;
                    if (bit_idx == 3'd7) state_nxt = STOP;
                    else bit_idx_nxt = bit_idx + 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            STOP: begin
                // Leave mid stop bit so a back-to-back start edge is caught.
                if (cnt == BIT_TC) begin
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                    if (rxd_s) bv_nxt = 1'b1;
                    else ferr_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: four 8N1 bytes assembled into one 32-bit word, offered on a
// valid/ready handshake with a single output register.
//   clk, rstn  clock, async active-low reset
//   rxd        serial input, idle high, asynchronous to clk
//   bus        uart_rx_if master: rdata/valid/ready handshake, ferr and ovr pulses
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_PER_BIT = UART_CLK_PER_BIT,
    parameter int CNT_W       = 16
) (
    input  logic      clk,
    input  logic      rstn,
    input  logic      rxd,
    uart_rx_if.master bus
);

    logic [7:0]  rx_byte;
    logic        byte_valid;
    logic        byte_ferr;
    logic [1:0]  idx;
    logic [23:0] asm_q;     // lanes 0..2; lane 3 goes straight to the output
    logic [31:0] rdata_q;
    logic        valid_q;
    logic        ovr_q;
    logic        word_done;

    uart_rx_byte #(.CLK_PER_BIT(CLK_PER_BIT), .CNT_W(CNT_W)) u_byte (
        .clk        (clk),
        .rstn       (rstn),
        .rxd        (rxd),
        .rx_byte    (rx_byte),
        .byte_valid (byte_valid),
        .ferr       (byte_ferr)
    );

    assign word_done = byte_valid && (idx == 2'd3);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            idx   <= '0;
            asm_q <= '0;
        end else if (byte_valid) begin
            case (idx)
                2'd0:    asm_q[7:0]   <= rx_byte;
                2'd1:    asm_q[15:8]  <= rx_byte;
                2'd2:    asm_q[23:16] <= rx_byte;
                default: ;
            endcase
            idx <= idx + 1'b1;
        end
    end

    // A word may replace the held one only if it is being taken this cycle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rdata_q <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            ovr_q <= 1'b0;
            if (word_done) begin
                if (!valid_q || bus.ready) begin
                    rdata_q <= {rx_byte, asm_q};
                    valid_q <= 1'b1;
                end else begin
                    ovr_q <= 1'b1;
                end
            end else if (valid_q && bus.ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign bus.rdata = rdata_q;
    assign bus.valid = valid_q;
    assign bus.ovr   = ovr_q;
    assign bus.ferr  = byte_ferr;

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;

    localparam int CPB   = 16;
    localparam int CNT_W = 8;
    // cycles from start-bit drive to valid: first edge, 2 sync flops,
    // half bit, 8 data bits + stop bit, output register
    localparam int LAT   = 1 + 2 + CPB / 2 + 9 * CPB + 1;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    logic rxd  = 1'b1;

    uart_rx_if bus ();

    uart_rx #(.CLK_PER_BIT(CPB), .CNT_W(CNT_W)) dut (
        .clk  (clk),
        .rstn (rstn),
        .rxd  (rxd),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // reference model: good bytes collected four at a time into words
    logic [7:0]  mdl_b[$];
    logic [31:0] exp_q[$];
    int exp_ferr = 0;
    int exp_ovr  = 0;
    int last_start = 0;

    // observed behaviour
    logic [31:0] got_q[$];
    int ferr_cnt = 0, ovr_cnt = 0, vld_cyc = 0, stab_err = 0, rise_cyc = 0;
    logic pv = 1'b0, pr = 1'b0;
    logic [31:0] prd = '0;

    always @(negedge clk) begin
        #1;
        if (!rstn) begin
            pv = 1'b0;
            pr = 1'b0;
        end else begin
            if (bus.valid && bus.ready) got_q.push_back(bus.rdata);
            if (bus.valid && !pv) rise_cyc = cyc;
            if (bus.valid) vld_cyc++;
            if (bus.ferr) ferr_cnt++;
            if (bus.ovr) ovr_cnt++;
            if (pv && !pr && (bus.valid !== 1'b1 || bus.rdata !== prd)) stab_err++;
            pv  = bus.valid;
            pr  = bus.ready;
            prd = bus.rdata;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // called at a negedge; returns at the negedge ending the stop bit
    task automatic send_byte(input logic [7:0] b, input bit ok);
        last_start = cyc;
        rxd = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (CPB) @(negedge clk);
        end
        rxd = ok;
        repeat (CPB) @(negedge clk);
        rxd = 1'b1;
        if (!ok) begin
            exp_ferr++;
            repeat (2 * CPB) @(negedge clk);
        end else begin
            mdl_b.push_back(b);
            if (mdl_b.size() == 4) begin
                exp_q.push_back({mdl_b[3], mdl_b[2], mdl_b[1], mdl_b[0]});
                mdl_b.delete();
            end
        end
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b1);
    endtask

    initial begin
        int base, c0;
        logic [31:0] w;
        bus.ready = 1'b1;

        // reset state
        repeat (3) @(negedge clk);
        check("reset_valid", {31'd0, bus.valid}, 32'd0);
        check("reset_rdata", bus.rdata, 32'd0);
        check("reset_ferr", {31'd0, bus.ferr}, 32'd0);
        check("reset_ovr", {31'd0, bus.ovr}, 32'd0);
        rstn = 1'b1;
        repeat (5) @(negedge clk);

        // 1: basic word, latency and single-cycle valid with ready high
        base = vld_cyc;
        send_word(32'h12345678);
        repeat (2) @(negedge clk);
        check("basic_latency", rise_cyc, last_start + LAT);
        check("basic_valid_cycles", vld_cyc - base, 1);
        check("basic_rdata", got_q[$], 32'h12345678);

        // random words, ready high
        for (int k = 0; k < 4; k++) begin
            w = $urandom;
            send_word(w);
            repeat (2) @(negedge clk);
            check("rand_word", got_q[$], w);
        end

        // 2: overrun
        bus.ready = 1'b0;
        send_word(32'hDEADBEEF);
        repeat (2) @(negedge clk);
        check("ovr_first_valid", {31'd0, bus.valid}, 32'd1);
        base = ovr_cnt;
        send_word(32'hCAFEF00D);
        void'(exp_q.pop_back());
        exp_ovr++;
        repeat (2) @(negedge clk);
        check("ovr_held_rdata", bus.rdata, 32'hDEADBEEF);
        check("ovr_held_valid", {31'd0, bus.valid}, 32'd1);
        check("ovr_pulses", ovr_cnt - base, 1);
        bus.ready = 1'b1;
        repeat (2) @(negedge clk);
        check("ovr_drain_valid", {31'd0, bus.valid}, 32'd0);
        send_word(32'h01020304);
        repeat (2) @(negedge clk);
        check("ovr_next_word", got_q[$], 32'h01020304);

        // 3: framing error drops one byte
        base = ferr_cnt;
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b1);
        send_byte(8'h44, 1'b1);
        send_byte(8'h55, 1'b1);
        repeat (2) @(negedge clk);
        check("ferr_pulses", ferr_cnt - base, 1);
        check("ferr_word", got_q[$], 32'h55443311);

        // 4: short glitch is ignored
        base = got_q.size();
        c0 = ferr_cnt;
        rxd = 1'b0;
        repeat (5) @(negedge clk);
        rxd = 1'b1;
        repeat (40) @(negedge clk);
        check("glitch_no_word", got_q.size(), base);
        check("glitch_no_ferr", ferr_cnt, c0);
        w = $urandom;
        send_word(w);
        repeat (2) @(negedge clk);
        check("glitch_next_word", got_q[$], w);

        // 5: reset mid-frame
        send_byte(8'($urandom), 1'b1);
        send_byte(8'($urandom), 1'b1);
        rxd = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            rxd = 1'($urandom);
            repeat (CPB) @(negedge clk);
        end
        rstn = 1'b0;
        rxd  = 1'b1;
        #1;
        check("rst_mid_valid", {31'd0, bus.valid}, 32'd0);
        check("rst_mid_rdata", bus.rdata, 32'd0);
        mdl_b.delete();
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        repeat (5) @(negedge clk);
        send_word(32'hD4C3B2A1);
        repeat (2) @(negedge clk);
        check("rst_next_word", got_q[$], 32'hD4C3B2A1);

        // 6: same-cycle handoff
        bus.ready = 1'b0;
        send_word(32'h00000000);
        repeat (2) @(negedge clk);
        check("hand_first_valid", {31'd0, bus.valid}, 32'd1);
        base = ovr_cnt;
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'hFF, 1'b1);
        c0 = cyc;
        fork
            send_byte(8'hFF, 1'b1);
            begin
                while (cyc < c0 + LAT - 1) @(negedge clk);
                bus.ready = 1'b1;
                @(negedge clk);
                bus.ready = 1'b0;
            end
        join
        check("hand_valid", {31'd0, bus.valid}, 32'd1);
        check("hand_rdata", bus.rdata, 32'hFFFF0000);
        check("hand_no_ovr", ovr_cnt - base, 0);
        bus.ready = 1'b1;
        repeat (3) @(negedge clk);

        // scoreboard
        check("word_count", got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            check("word_seq", got_q[i], exp_q[i]);
        check("ferr_total", ferr_cnt, exp_ferr);
        check("ovr_total", ovr_cnt, exp_ovr);
        check("stable_while_stalled", stab_err, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
